// File: rtl/cog_ctr_seq_if.sv
// Bundle of the requester handshakes and the counter write bus shared by the
// cog control logic (master) and the counter programming sequencer (slave).
interface cog_ctr_seq_if;
  logic        req_a;
  logic [2:0]  mask_a;
  logic [31:0] ctr_a;
  logic [31:0] frq_a;
  logic [31:0] phs_a;
  logic        ack_a;

  logic        req_b;
  logic [2:0]  mask_b;
  logic [31:0] ctr_b;
  logic [31:0] frq_b;
  logic [31:0] phs_b;
  logic        ack_b;

  logic        setctr;
  logic        setfrq;
  logic        setphs;
  logic [31:0] data;
  logic        busy;
  logic        owner;

  // Requesting side: raises requests, watches acks and the write bus.
  modport master (
    output req_a, mask_a, ctr_a, frq_a, phs_a,
    output req_b, mask_b, ctr_b, frq_b, phs_b,
    input  ack_a, ack_b,
    input  setctr, setfrq, setphs, data, busy, owner
  );

  // Sequencer side.
  modport slave (
    input  req_a, mask_a, ctr_a, frq_a, phs_a,
    input  req_b, mask_b, ctr_b, frq_b, phs_b,
    output ack_a, ack_b,
    output setctr, setfrq, setphs, data, busy, owner
  );
endinterface

// File: rtl/cog_ctr_seq.sv
// Cog counter programming sequencer: round-robin arbitration between two
// requesters, captures the winner's CTR/FRQ/PHS values and writes them in the
// safe order stop counter -> FRQ -> PHS -> start counter, optionally spacing
// the writes with GAP idle cycles. All outputs come straight from flops.
module cog_ctr_seq #(
  parameter int unsigned GAP = 0
) (
  input  logic clk_cog,
  input  logic ena,
  cog_ctr_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, STOP, FRQ, PHS, CTR, WAIT, DONE
  } state_t;

  // WAIT is entered already holding its first cycle, so it loads GAP-1.
  localparam logic [3:0] GAP_M1 = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t      state_reg, state_next;
  state_t      pend_reg, pend_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;
  logic [2:0]  mask_reg, mask_next;
  logic [31:0] ctr_reg, ctr_next;
  logic [31:0] frq_reg, frq_next;
  logic [31:0] phs_reg, phs_next;

  logic        setctr_reg, setctr_next;
  logic        setfrq_reg, setfrq_next;
  logic        setphs_reg, setphs_next;
  logic [31:0] data_reg, data_next;
  logic        busy_reg, busy_next;
  logic [1:0]  ack_reg, ack_next;

  logic        winner;
  state_t      step_next;

  // Next write step after state s for mask m; the CTR mask bit gates both the
  // stop and the restart write. IDLE means "first step of a new transaction".
  function automatic state_t step_after(input state_t s, input logic [2:0] m);
    state_t r;
    r = DONE;
    case (s)
      IDLE: r = m[0] ? STOP : (m[1] ? FRQ : (m[2] ? PHS : DONE));
      STOP: r = m[1] ? FRQ : (m[2] ? PHS : CTR);
      FRQ:  r = m[2] ? PHS : (m[0] ? CTR : DONE);
      PHS:  r = m[0] ? CTR : DONE;
      default: r = DONE;
    endcase
    return r;
  endfunction

  // Arbitration, capture and step sequencing.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    mask_next  = mask_reg;
    ctr_next   = ctr_reg;
    frq_next   = frq_reg;
    phs_next   = phs_reg;
    winner     = 1'b0;
    step_next  = DONE;
    case (state_reg)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          // On a tie the requester that did not go last wins.
          winner     = (bus.req_a && bus.req_b) ? ~owner_reg : bus.req_b;
          owner_next = winner;
          mask_next  = winner ? bus.mask_b : bus.mask_a;
          ctr_next   = winner ? bus.ctr_b  : bus.ctr_a;
          frq_next   = winner ? bus.frq_b  : bus.frq_a;
          phs_next   = winner ? bus.phs_b  : bus.phs_a;
          state_next = step_after(IDLE, mask_next);
        end
      end
      STOP, FRQ, PHS, CTR: begin
        step_next = step_after(state_reg, mask_reg);
        if (step_next == DONE || GAP == 0) begin
          state_next = step_next;
        end else begin
          state_next = WAIT;
          pend_next  = step_next;
          cnt_next   = GAP_M1;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = pend_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so strobes line up with the state.
  always_comb begin
    setctr_next = (state_next == STOP) || (state_next == CTR);
    setfrq_next = (state_next == FRQ);
    setphs_next = (state_next == PHS);
    busy_next   = (state_next != IDLE);
    case (state_next)
      FRQ:     data_next = frq_next;
      PHS:     data_next = phs_next;
      CTR:     data_next = ctr_next;
      default: data_next = 32'd0;
    endcase
  end

  // One ack line per requester, raised in the DONE cycle of its transaction.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_next[gi] = (state_next == DONE) && (owner_next == 1'(gi));
    end
  endgenerate

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      state_reg  <= IDLE;
      pend_reg   <= IDLE;
      cnt_reg    <= 4'd0;
      owner_reg  <= 1'b1;
      mask_reg   <= 3'd0;
      ctr_reg    <= 32'd0;
      frq_reg    <= 32'd0;
      phs_reg    <= 32'd0;
      setctr_reg <= 1'b0;
      setfrq_reg <= 1'b0;
      setphs_reg <= 1'b0;
      data_reg   <= 32'd0;
      busy_reg   <= 1'b0;
      ack_reg    <= 2'b00;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      cnt_reg    <= cnt_next;
      owner_reg  <= owner_next;
      mask_reg   <= mask_next;
      ctr_reg    <= ctr_next;
      frq_reg    <= frq_next;
      phs_reg    <= phs_next;
      setctr_reg <= setctr_next;
      setfrq_reg <= setfrq_next;
      setphs_reg <= setphs_next;
      data_reg   <= data_next;
      busy_reg   <= busy_next;
      ack_reg    <= ack_next;
    end
  end

  assign bus.setctr = setctr_reg;
  assign bus.setfrq = setfrq_reg;
  assign bus.setphs = setphs_reg;
  assign bus.data   = data_reg;
  assign bus.busy   = busy_reg;
  assign bus.owner  = owner_reg;
  assign bus.ack_a  = ack_reg[0];
  assign bus.ack_b  = ack_reg[1];

endmodule

// File: tb/tb_cog_ctr_seq.sv
// Directed bench for cog_ctr_seq: a per-cycle vector table on a GAP=0
// instance plus hand-written sequences for spacing, capture and reset abort.
module tb_cog_ctr_seq;

  localparam logic [31:0] A_CTR = 32'h1400_0005;
  localparam logic [31:0] A_FRQ = 32'h0000_1000;
  localparam logic [31:0] A_PHS = 32'h0000_0010;
  localparam logic [31:0] B_CTR = 32'hB000_000C;
  localparam logic [31:0] B_FRQ = 32'h0000_B0F0;
  localparam logic [31:0] B_PHS = 32'h0000_00B1;
  // {setphs,setfrq,setctr, data, busy, owner, ack_a, ack_b} after reset
  localparam logic [38:0] RST_VAL = {3'b000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic clk_cog = 1'b0;
  logic ena = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_cog = ~clk_cog;

  cog_ctr_seq_if if0 ();
  cog_ctr_seq_if if3 ();

  cog_ctr_seq #(.GAP(0)) dut0 (.clk_cog(clk_cog), .ena(ena), .bus(if0.slave));
  cog_ctr_seq #(.GAP(3)) dut3 (.clk_cog(clk_cog), .ena(ena), .bus(if3.slave));

  typedef struct {
    string      name;
    bit         rst_before;
    logic       req_a;
    logic [2:0] mask_a;
    logic       req_b;
    logic [2:0] mask_b;
    logic [2:0] strb;   // {setphs, setfrq, setctr}
    logic [31:0] data;
    logic       busy;
    logic       owner;
    logic       ack_a;
    logic       ack_b;
  } vec_t;

  vec_t tv[$];

  function automatic logic [38:0] pk0();
    return {if0.setphs, if0.setfrq, if0.setctr, if0.data, if0.busy, if0.owner, if0.ack_a, if0.ack_b};
  endfunction

  function automatic logic [38:0] pk3();
    return {if3.setphs, if3.setfrq, if3.setctr, if3.data, if3.busy, if3.owner, if3.ack_a, if3.ack_b};
  endfunction

  task automatic check(input string nm, input logic [38:0] got, input logic [38:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h required=%h", nm, got, exp);
    end else begin
      $display("[%0t] %s: outputs=%h", $time, nm, got);
    end
  endtask

  task automatic add(input string nm, input bit rb, input logic ra, input logic [2:0] ma,
                     input logic rq_b, input logic [2:0] mb, input logic [2:0] st,
                     input logic [31:0] d, input logic bz, input logic ow,
                     input logic aa, input logic ab);
    vec_t v;
    v.name = nm; v.rst_before = rb; v.req_a = ra; v.mask_a = ma; v.req_b = rq_b;
    v.mask_b = mb; v.strb = st; v.data = d; v.busy = bz; v.owner = ow;
    v.ack_a = aa; v.ack_b = ab;
    tv.push_back(v);
  endtask

  task automatic load_values();
    if0.ctr_a = A_CTR; if0.frq_a = A_FRQ; if0.phs_a = A_PHS;
    if0.ctr_b = B_CTR; if0.frq_b = B_FRQ; if0.phs_b = B_PHS;
    if3.ctr_a = A_CTR; if3.frq_a = A_FRQ; if3.phs_a = A_PHS;
    if3.ctr_b = B_CTR; if3.frq_b = B_FRQ; if3.phs_b = B_PHS;
  endtask

  task automatic clear_reqs();
    if0.req_a = 1'b0; if0.req_b = 1'b0; if0.mask_a = 3'd0; if0.mask_b = 3'd0;
    if3.req_a = 1'b0; if3.req_b = 1'b0; if3.mask_a = 3'd0; if3.mask_b = 3'd0;
  endtask

  task automatic do_reset();
    @(posedge clk_cog); #2;
    ena = 1'b0;
    clear_reqs();
    @(posedge clk_cog); @(posedge clk_cog); #2;
    ena = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [38:0] exp;
    logic [2:0]  st;
    logic [31:0] d;

    clear_reqs();
    load_values();

    // ---------------- vector table (GAP=0 instance) ----------------
    // full mask, requester A
    add("full_stop", 1, 1, 7, 0, 0, 3'b001, 32'd0, 1, 0, 0, 0);
    add("full_frq",  0, 1, 7, 0, 0, 3'b010, A_FRQ, 1, 0, 0, 0);
    add("full_phs",  0, 1, 7, 0, 0, 3'b100, A_PHS, 1, 0, 0, 0);
    add("full_ctr",  0, 1, 7, 0, 0, 3'b001, A_CTR, 1, 0, 0, 0);
    add("full_ack",  0, 1, 7, 0, 0, 3'b000, 32'd0, 1, 0, 1, 0);
    add("full_idle", 0, 0, 0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0);
    // both requesting, held: A, B, A
    add("rr_a1",     1, 1, 2, 1, 2, 3'b010, A_FRQ, 1, 0, 0, 0);
    add("rr_a1_ack", 0, 1, 2, 1, 2, 3'b000, 32'd0, 1, 0, 1, 0);
    add("rr_gap1",   0, 1, 2, 1, 2, 3'b000, 32'd0, 0, 0, 0, 0);
    add("rr_b",      0, 1, 2, 1, 2, 3'b010, B_FRQ, 1, 1, 0, 0);
    add("rr_b_ack",  0, 1, 2, 1, 2, 3'b000, 32'd0, 1, 1, 0, 1);
    add("rr_gap2",   0, 1, 2, 1, 2, 3'b000, 32'd0, 0, 1, 0, 0);
    add("rr_a2",     0, 1, 2, 1, 2, 3'b010, A_FRQ, 1, 0, 0, 0);
    add("rr_a2_ack", 0, 0, 0, 0, 0, 3'b000, 32'd0, 1, 0, 1, 0);
    add("rr_idle",   0, 0, 0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0);
    // mask=4 from B: PHS only
    add("m4_phs",    0, 0, 0, 1, 4, 3'b100, B_PHS, 1, 1, 0, 0);
    add("m4_ack",    0, 0, 0, 1, 4, 3'b000, 32'd0, 1, 1, 0, 1);
    add("m4_idle",   0, 0, 0, 0, 0, 3'b000, 32'd0, 0, 1, 0, 0);
    // mask=1 from A: stop (data 0) then restart with ctr
    add("m1_stop",   0, 1, 1, 0, 0, 3'b001, 32'd0, 1, 0, 0, 0);
    add("m1_ctr",    0, 1, 1, 0, 0, 3'b001, A_CTR, 1, 0, 0, 0);
    add("m1_ack",    0, 1, 1, 0, 0, 3'b000, 32'd0, 1, 0, 1, 0);
    add("m1_idle",   0, 0, 0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0);
    // mask=0: straight to ack
    add("m0_ack",    0, 1, 0, 0, 0, 3'b000, 32'd0, 1, 0, 1, 0);
    add("m0_idle",   0, 0, 0, 0, 0, 3'b000, 32'd0, 0, 0, 0, 0);

    // reset state of both instances
    @(posedge clk_cog); @(posedge clk_cog); #2;
    check("reset_gap0", pk0(), RST_VAL);
    check("reset_gap3", pk3(), RST_VAL);
    ena = 1'b1;

    foreach (tv[i]) begin
      if (tv[i].rst_before) do_reset();
      if0.req_a = tv[i].req_a; if0.mask_a = tv[i].mask_a;
      if0.req_b = tv[i].req_b; if0.mask_b = tv[i].mask_b;
      @(posedge clk_cog); #2;
      exp = {tv[i].strb, tv[i].data, tv[i].busy, tv[i].owner, tv[i].ack_a, tv[i].ack_b};
      check(tv[i].name, pk0(), exp);
    end

    // ---------------- GAP=3, full mask: writes at t=1,5,9,13, ack at 14 ----------------
    do_reset();
    if3.req_a = 1'b1; if3.mask_a = 3'd7;
    for (int t = 1; t <= 16; t++) begin
      @(posedge clk_cog); #2;
      st = 3'b000; d = 32'd0;
      if (t == 1)  begin st = 3'b001; d = 32'd0; end
      if (t == 5)  begin st = 3'b010; d = A_FRQ; end
      if (t == 9)  begin st = 3'b100; d = A_PHS; end
      if (t == 13) begin st = 3'b001; d = A_CTR; end
      exp = {st, d, (t <= 14) ? 1'b1 : 1'b0, 1'b0, (t == 14) ? 1'b1 : 1'b0, 1'b0};
      check($sformatf("gap3_t%0d", t), pk3(), exp);
      if (t == 14) if3.req_a = 1'b0;
    end

    // ---------------- capture: inputs change and req drops after grant ----------------
    do_reset();
    if0.req_a = 1'b1; if0.mask_a = 3'd7;
    @(posedge clk_cog); #2;
    check("cap_stop", pk0(), {3'b001, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    if0.req_a = 1'b0; if0.mask_a = 3'd0;
    if0.ctr_a = 32'hDEAD_0001; if0.frq_a = 32'hDEAD_0002; if0.phs_a = 32'hDEAD_0003;
    @(posedge clk_cog); #2;
    check("cap_frq", pk0(), {3'b010, A_FRQ, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge clk_cog); #2;
    check("cap_phs", pk0(), {3'b100, A_PHS, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge clk_cog); #2;
    check("cap_ctr", pk0(), {3'b001, A_CTR, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge clk_cog); #2;
    check("cap_ack", pk0(), {3'b000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(posedge clk_cog); #2;
    check("cap_idle", pk0(), {3'b000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    load_values();

    // ---------------- reset during the PHS write ----------------
    do_reset();
    if0.req_a = 1'b1; if0.mask_a = 3'd7;
    @(posedge clk_cog); @(posedge clk_cog); @(posedge clk_cog); #2;
    check("abort_phs", pk0(), {3'b100, A_PHS, 1'b1, 1'b0, 1'b0, 1'b0});
    #2;
    ena = 1'b0;
    #1;
    check("abort_async", pk0(), RST_VAL);
    if0.req_a = 1'b0; if0.mask_a = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_cog); #2;
      check($sformatf("abort_hold%0d", k), pk0(), RST_VAL);
    end
    ena = 1'b1;
    @(posedge clk_cog); #2;
    check("abort_no_ack", pk0(), RST_VAL);
    if0.req_a = 1'b1; if0.mask_a = 3'd2;
    if0.req_b = 1'b1; if0.mask_b = 3'd2;
    @(posedge clk_cog); #2;
    check("post_grant_a", pk0(), {3'b010, A_FRQ, 1'b1, 1'b0, 1'b0, 1'b0});
    if0.req_a = 1'b0; if0.req_b = 1'b0;
    @(posedge clk_cog); #2;
    check("post_ack_a", pk0(), {3'b000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(posedge clk_cog); #2;
    check("post_idle", pk0(), {3'b000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cog_ctr_seq.md
Name: cog_ctr_seq

Overview:
- Sequencer that programs one cog counter (CTR/FRQ/PHS) on behalf of two requesters, A and B.
- Arbitrates round-robin between them and captures the winning requester's configuration.
- Emits the setctr/setfrq/setphs strobes plus a shared data bus in a fixed safe order: stop counter, load FRQ, load PHS, start counter.
- Sits between cog control logic and the counter datapath.

Parameters:
GAP, 0, idle cycles (0..15) inserted between consecutive register writes

Ports:
clk_cog  input  1  cog clock; all state updates on posedge
ena  input  1  reset; asynchronous, active-low, clears all state
req_a  input  1  requester A asks for a programming transaction
mask_a  input  3  A write mask: [0]=CTR, [1]=FRQ, [2]=PHS
ctr_a  input  32  A CTR value
frq_a  input  32  A FRQ value
phs_a  input  32  A PHS value
ack_a  output  1  one-cycle pulse when A's transaction completes
req_b, mask_b, ctr_b, frq_b, phs_b, ack_b  same as the A ports, for requester B
setctr  output  1  CTR write strobe
setfrq  output  1  FRQ write strobe
setphs  output  1  PHS write strobe
data  output  32  write data; valid while any strobe is high, 0 otherwise
busy  output  1  high from grant until the ack cycle inclusive
owner  output  1  current/last granted requester (0=A, 1=B)

Behaviour:
- All outputs are registered.
- Reset (ena low, async): state IDLE, all strobes/acks/busy/data = 0, owner = 1 so A wins the first tie. Reset mid-transaction aborts immediately, strobes drop in the same instant, and no ack is issued.
- States: IDLE, STOP, FRQ, PHS, CTR, WAIT, DONE.
- IDLE: sample req_a/req_b at each edge.
  - Single request: grant it.
  - Both requesting: grant the one != owner.
  - On grant: owner <= winner; mask/ctr/frq/phs are captured into internal registers (later input changes are ignored); busy <= 1.
  - Next state is the first active step of the ordered list STOP(mask[0]), FRQ(mask[1]), PHS(mask[2]), CTR(mask[0]).
  - mask = 0 goes straight to DONE.
- STOP: setctr=1, data=0.
- FRQ: setfrq=1, data=captured frq.
- PHS: setphs=1, data=captured phs.
- CTR: setctr=1, data=captured ctr.
- Each write state lasts exactly one cycle. At most one strobe is high in any cycle.
- Between two write states, WAIT holds all strobes low for GAP cycles using a 4-bit down-counter. GAP=0 means WAIT is skipped. There is no WAIT after the final write.
- DONE (one cycle): ack of owner = 1, busy = 1, then IDLE. Arbitration resumes in IDLE, so the minimum spacing between transactions is one IDLE cycle.
- Latency, full mask, GAP=0, grant at edge N:
  - STOP cycle N+1, FRQ N+2, PHS N+3, CTR N+4, ack N+5, IDLE N+6.
  - Total cycles = 1 + writes + GAP*(writes-1) + 1.
- Handshake:
  - req must be held until ack. If req drops early, the transaction still completes and ack still pulses.
  - req still high in the IDLE after ack counts as a new request; round-robin then favours the other requester if it is requesting.
- A request arriving while busy waits; it is not queued beyond its level-sensitive req.
- owner is stable outside grant edges.

Test Plan:
- Reset then req_a=1, mask_a=7, ctr_a=0x1400_0005, frq_a=0x0000_1000, phs_a=0x10, GAP=0 -> cycles N+1..N+4: setctr/data=0, setfrq/0x1000, setphs/0x10, setctr/0x1400_0005; ack_a at N+5; busy high N+1..N+5.
- req_a and req_b asserted together and held, masks=2 -> A granted first (owner=0), then B (owner=1), then A; acks alternate; no strobe overlap.
- GAP=3, mask=7 -> exactly 3 strobe-free cycles between each pair of writes; ack 14 cycles after grant; none after the final write.
- mask=0 -> no strobes; ack one cycle after the grant-edge cycle; mask=4 -> only setphs; mask=1 -> setctr data 0, then setctr data ctr.
- Change ctr_a/frq_a after grant and drop req_a mid-transaction -> captured values are written and ack_a still pulses.
- Assert ena low during the PHS write -> strobes, busy and data = 0 asynchronously, no ack; after release, a new req is accepted normally and owner=1 tie-break gives A priority.
